// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and constants for the execute sequencer
package exec_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_ADC = 3'd5,
      OP_LDI = 3'd6,
      OP_CMP = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_RD_F = 3'd3,
      S_EXEC = 3'd4,
      S_WR_D = 3'd5,
      S_WR_F = 3'd6,
      S_DONE = 3'd7
   } state_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   localparam logic [1:0] REG_EFLAGS = 2'd3;

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational 8-bit ALU producing result and eflags image
module alu8
   import exec_pkg::*;
(
   input  op_e        op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   input  logic [7:0] imm,
   output logic [7:0] result,
   output logic [7:0] flags
);

   logic [8:0] wide;
   logic       c;
   logic       v;

   always_comb begin
      wide   = '0;
      c      = 1'b0;
      v      = 1'b0;
      result = '0;
      case (op)
         OP_ADD, OP_ADC: begin
            wide   = {1'b0, a} + {1'b0, b} + {8'b0, (op == OP_ADC) ? cin : 1'b0};
            result = wide[7:0];
            c      = wide[8];
            v      = (a[7] == b[7]) && (result[7] != a[7]);
         end
         OP_SUB, OP_CMP: begin
            // bit 8 of the 9-bit difference is the unsigned borrow
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[7:0];
            c      = wide[8];
            v      = (a[7] != b[7]) && (result[7] != a[7]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_LDI:  result = imm;
         default: result = '0;
      endcase
      flags         = '0;
      flags[FLAG_C] = c;
      flags[FLAG_Z] = (result == 8'h00);
      flags[FLAG_N] = result[7];
      flags[FLAG_V] = v;
   end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - fixed-latency execute controller on the shared register-file port
module exec_sequencer
   import exec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [1:0] rd,
   input  logic [1:0] rs1,
   input  logic [1:0] rs2,
   input  logic [7:0] imm,
   output logic       busy,
   output logic       done,
   output logic       rf_we,
   output logic [2:0] rf_reg_no,
   output logic [7:0] rf_wdata,
   input  logic [7:0] rf_rdata
);

   state_e     state_q, state_d;
   op_e        op_q, op_d;
   logic [1:0] rd_q, rd_d;
   logic [1:0] rs1_q, rs1_d;
   logic [1:0] rs2_q, rs2_d;
   logic [7:0] imm_q, imm_d;
   logic [7:0] opa_q, opa_d;
   logic [7:0] opb_q, opb_d;
   logic [7:0] flg_q, flg_d;
   logic [7:0] nflg_q, nflg_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       we_q, we_d;
   logic [2:0] reg_no_q, reg_no_d;
   logic [7:0] wdata_q, wdata_d;

   logic [7:0] alu_result;
   logic [7:0] alu_flags;

   alu8 u_alu (
      .op     (op_q),
      .a      (opa_q),
      .b      (opb_q),
      .cin    (flg_q[FLAG_C]),
      .imm    (imm_q),
      .result (alu_result),
      .flags  (alu_flags)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      imm_d   = imm_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      flg_d   = flg_q;
      nflg_d  = nflg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RD_A;
               op_d    = op_e'(op);
               rd_d    = rd;
               rs1_d   = rs1;
               rs2_d   = rs2;
               imm_d   = imm;
            end
         end
         S_RD_A: begin
            opa_d   = rf_rdata;
            state_d = S_RD_B;
         end
         S_RD_B: begin
            opb_d   = rf_rdata;
            state_d = S_RD_F;
         end
         S_RD_F: begin
            flg_d   = rf_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            nflg_d  = alu_flags;
            state_d = S_WR_D;
         end
         S_WR_D:  state_d = S_WR_F;
         S_WR_F:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // outputs are decoded from the next state so they come straight from flops
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
      we_d     = 1'b0;
      reg_no_d = 3'd0;
      wdata_d  = 8'h00;
      case (state_d)
         S_RD_A: reg_no_d = {1'b0, rs1_d};
         S_RD_B: reg_no_d = {1'b0, rs2_d};
         S_RD_F: reg_no_d = {1'b0, REG_EFLAGS};
         S_WR_D: begin
            reg_no_d = {1'b0, rd_d};
            we_d     = (op_d != OP_CMP) && (rd_d != REG_EFLAGS);
            wdata_d  = alu_result;
         end
         S_WR_F: begin
            reg_no_d = {1'b0, REG_EFLAGS};
            we_d     = 1'b1;
            wdata_d  = nflg_d;
         end
         default: reg_no_d = 3'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         flg_q    <= '0;
         nflg_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         reg_no_q <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         flg_q    <= flg_d;
         nflg_q   <= nflg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         we_q     <= we_d;
         reg_no_q <= reg_no_d;
         wdata_q  <= wdata_d;
      end
   end

   // a write pending in the reset cycle must not reach the register file
   assign rf_we     = we_q & ~rst;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rf_reg_no = reg_no_q;
   assign rf_wdata  = wdata_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - bench for exec_sequencer with register-file model and alu8 vectors
module tb_exec_sequencer;
   import exec_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] op;
   logic [1:0] rd, rs1, rs2;
   logic [7:0] imm;
   logic       busy, done, rf_we;
   logic [2:0] rf_reg_no;
   logic [7:0] rf_wdata, rf_rdata;
   logic [7:0] rf [4];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   exec_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm       (imm),
      .busy      (busy),
      .done      (done),
      .rf_we     (rf_we),
      .rf_reg_no (rf_reg_no),
      .rf_wdata  (rf_wdata),
      .rf_rdata  (rf_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else if (rf_we) begin
         rf[rf_reg_no[1:0]] <= rf_wdata;
      end
   end
   assign rf_rdata = rf[rf_reg_no[1:0]];

   op_e        tv_op;
   logic [7:0] tv_a, tv_b, tv_imm, tv_res, tv_flg;
   logic       tv_cin;

   alu8 u_alu_tv (
      .op     (tv_op),
      .a      (tv_a),
      .b      (tv_b),
      .cin    (tv_cin),
      .imm    (tv_imm),
      .result (tv_res),
      .flags  (tv_flg)
   );

   typedef struct {
      op_e        o;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] im;
      logic [7:0] exp_res;
      logic [7:0] exp_flg;
   } alu_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // called at a negedge with the FSM idle; returns at the negedge of cycle t+8
   task automatic do_instr(input op_e o, input logic [1:0] d, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [7:0] im, input logic exp_we,
                           input logic [7:0] exp_res, input logic [7:0] exp_ef);
      start = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
      @(posedge clk); #1;
      start = 1'b0;
      op = 3'($urandom); rd = 2'($urandom); rs1 = 2'($urandom);
      rs2 = 2'($urandom); imm = 8'($urandom);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("busy_t%0d", k), busy, 1);
         chk($sformatf("done_t%0d", k), done, (k == 7));
         if (k == 1) chk("reg_no_rd_a", rf_reg_no, {1'b0, s1});
         if (k == 2) chk("reg_no_rd_b", rf_reg_no, {1'b0, s2});
         if (k == 3) chk("reg_no_rd_f", rf_reg_no, 3);
         if (k == 5) begin
            chk("wr_d_reg_no", rf_reg_no, {1'b0, d});
            chk("wr_d_we", rf_we, exp_we);
            chk("wr_d_wdata", rf_wdata, exp_res);
         end
         if (k == 6) begin
            chk("wr_f_reg_no", rf_reg_no, 3);
            chk("wr_f_we", rf_we, 1);
            chk("wr_f_wdata", rf_wdata, exp_ef);
         end
      end
      @(negedge clk);
      chk("busy_t8", busy, 0);
      if (exp_we) chk($sformatf("rf_r%0d", d), rf[d], exp_res);
      chk("rf_eflags", rf[3], exp_ef);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      alu_vec_t vecs[13];
      int accepts;
      logic prev_busy;

      vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h80, 8'h0C};
      vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 8'h03};
      vecs[2]  = '{OP_ADC, 8'h01, 8'h01, 1'b1, 8'h00, 8'h03, 8'h00};
      vecs[3]  = '{OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 8'h03};
      vecs[4]  = '{OP_SUB, 8'h05, 8'h03, 1'b0, 8'h00, 8'h02, 8'h00};
      vecs[5]  = '{OP_SUB, 8'h03, 8'h05, 1'b0, 8'h00, 8'hFE, 8'h05};
      vecs[6]  = '{OP_SUB, 8'h80, 8'h01, 1'b1, 8'h00, 8'h7F, 8'h08};
      vecs[7]  = '{OP_CMP, 8'h01, 8'hFF, 1'b0, 8'h00, 8'h02, 8'h01};
      vecs[8]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h00, 8'h30, 8'h00};
      vecs[9]  = '{OP_OR,  8'h00, 8'h00, 1'b0, 8'h55, 8'h00, 8'h02};
      vecs[10] = '{OP_XOR, 8'hFF, 8'h0F, 1'b0, 8'h00, 8'hF0, 8'h04};
      vecs[11] = '{OP_LDI, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 8'h02};
      vecs[12] = '{OP_AND, 8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 8'h04};

      rst = 1'b1; start = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_reg_no", rf_reg_no, 0);
      chk("rst_wdata", rf_wdata, 0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         tv_op = vecs[i].o; tv_a = vecs[i].a; tv_b = vecs[i].b;
         tv_cin = vecs[i].cin; tv_imm = vecs[i].im;
         #1;
         chk($sformatf("alu_res_v%0d", i), tv_res, vecs[i].exp_res);
         chk($sformatf("alu_flg_v%0d", i), tv_flg, vecs[i].exp_flg);
      end
      @(negedge clk);

      do_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h7F, 1'b1, 8'h7F, 8'h00);
      do_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h01, 1'b1, 8'h01, 8'h00);
      do_instr(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 8'h80, 8'h0C);
      do_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b1, 8'hFF, 8'h04);
      do_instr(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 8'h00, 8'h03);
      do_instr(OP_ADC, 2'd2, 2'd1, 2'd1, 8'h00, 1'b1, 8'h03, 8'h00);
      do_instr(OP_CMP, 2'd2, 2'd1, 2'd0, 8'h00, 1'b0, 8'h02, 8'h01);
      chk("cmp_r0", rf[0], 8'hFF);
      chk("cmp_r1", rf[1], 8'h01);
      chk("cmp_r2", rf[2], 8'h03);
      do_instr(OP_LDI, 2'd3, 2'd0, 2'd0, 8'hAA, 1'b0, 8'hAA, 8'h04);
      do_instr(OP_ADD, 2'd0, 2'd3, 2'd1, 8'h00, 1'b1, 8'h05, 8'h00);

      // start held high for 20 cycles
      start = 1'b1; op = OP_LDI; rd = 2'd0; rs1 = 2'd0; rs2 = 2'd0; imm = 8'h05;
      accepts = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("sat_busy_e%0d", i), busy, (i % 8 != 7));
         chk($sformatf("sat_done_e%0d", i), done, (i % 8 == 6));
         if (busy && !prev_busy) accepts++;
         prev_busy = busy;
      end
      start = 1'b0;
      chk("sat_accepts", accepts, 3);
      repeat (5) @(negedge clk);
      chk("sat_idle", busy, 0);
      chk("sat_r0", rf[0], 8'h05);

      // reset while a destination write is pending
      start = 1'b1; op = OP_ADD; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd1; imm = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_we", rf_we, 1);
      chk("pre_rst_wdata", rf_wdata, 8'h06);
      rst = 1'b1;
      #1;
      chk("rst_cycle_we", rf_we, 0);
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_we", rf_we, 0);
      chk("post_rst_reg_no", rf_reg_no, 0);
      chk("post_rst_wdata", rf_wdata, 0);
      chk("post_rst_r2", rf[2], 8'h00);
      rst = 1'b0;
      do_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h5A, 1'b1, 8'h5A, 8'h00);
      chk("post_rst_r2_kept", rf[2], 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
